// File: rtl/coef_pkg.sv
// Shared definitions for the coefficient page loader: FSM states, sizing defaults,
// and the coef_mux select codes.
package coef_pkg;

  localparam int NUM_COEF       = 33;
  localparam int PAGE_WORDS     = 10;
  localparam int COMMIT_CYCLES  = 2;
  localparam int PARK_MUX       = 15;
  localparam int PAGE_BUF_WORDS = 10;

  localparam logic [31:0] MUX_BYPASS = 32'd0;
  localparam logic [31:0] MUX_PAGE1  = 32'd1;
  localparam logic [31:0] MUX_PAGE2  = 32'd2;
  localparam logic [31:0] MUX_PAGE3  = 32'd3;
  localparam logic [31:0] MUX_PAGE4  = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4,
    ST_BYPASS = 3'd5
  } coef_state_e;

  function automatic int num_pages(input int n_coef, input int page_words);
    return (n_coef + page_words - 1) / page_words;
  endfunction

  function automatic logic [31:0] page_mux(input logic [2:0] page, input logic [31:0] park);
    logic [31:0] code;
    case (page)
      3'd1:    code = MUX_PAGE1;
      3'd2:    code = MUX_PAGE2;
      3'd3:    code = MUX_PAGE3;
      3'd4:    code = MUX_PAGE4;
      default: code = park;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/coef_page_buf.sv
// Ten-word coefficient page register: indexed write, zero-fill of the words above
// the write index, and whole-page clear.
module coef_page_buf
  import coef_pkg::*;
#(
  parameter int DEPTH = PAGE_BUF_WORDS,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic                    zfill,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [31:0]             wr_data,
  output logic [DEPTH-1:0][31:0]  words
);

  logic [DEPTH-1:0][31:0] mem_r;

  // page storage; zfill blanks every slot above the word being written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_r <= '0;
    end else if (clr) begin
      mem_r <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (IDX_W'(k) == wr_idx) begin
          mem_r[k] <= wr_data;
        end else if (zfill && (IDX_W'(k) > wr_idx)) begin
          mem_r[k] <= 32'd0;
        end else begin
          mem_r[k] <= mem_r[k];
        end
      end
    end else begin
      mem_r <= mem_r;
    end
  end

  assign words = mem_r;

endmodule

// File: rtl/coef_page_loader.sv
// Streams a coefficient frame into pages and presents each page on coef_mux.
// Optional COEF_CHECKSUM_EN adds a per-frame modulo-2^32 coefficient checksum.
module coef_page_loader #(
  parameter int NUM_COEF      = coef_pkg::NUM_COEF,
  parameter int PAGE_WORDS    = coef_pkg::PAGE_WORDS,
  parameter int COMMIT_CYCLES = coef_pkg::COMMIT_CYCLES,
  parameter int PARK_MUX      = coef_pkg::PARK_MUX
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic [31:0] coef_data,
  input  logic        coef_last,
  input  logic        bypass_req,
  output logic [31:0] coef_mux,
  output logic [31:0] page_word_0,
  output logic [31:0] page_word_1,
  output logic [31:0] page_word_2,
  output logic [31:0] page_word_3,
  output logic [31:0] page_word_4,
  output logic [31:0] page_word_5,
  output logic [31:0] page_word_6,
  output logic [31:0] page_word_7,
  output logic [31:0] page_word_8,
  output logic [31:0] page_word_9,
  output logic        busy,
  output logic        done,
  output logic        err_short,
  output logic        err_long,
  output logic [31:0] checksum
);

  import coef_pkg::*;

  localparam int NUM_PAGES  = num_pages(NUM_COEF, PAGE_WORDS);
  localparam int LAST_WORDS = NUM_COEF - (NUM_PAGES - 1) * PAGE_WORDS;
  localparam int IDX_W      = 4;
  localparam int PAGE_W     = 3;
  localparam int CYC_W      = $clog2(COMMIT_CYCLES + 1);

  coef_state_e              state_r, state_s;
  logic [PAGE_W-1:0]        page_r, page_s;
  logic [IDX_W-1:0]         idx_r, idx_s;
  logic [CYC_W-1:0]         cyc_r, cyc_s;
  logic                     last_seen_r, last_seen_s;
  logic                     coef_ready_r, busy_r, done_r, err_short_r, err_long_r;
  logic [31:0]              coef_mux_r;
  logic                     accept_s, final_page_s, page_full_s;
  logic                     buf_clr_s, buf_wr_s, buf_zfill_s;
  logic                     set_short_s, set_long_s, clr_err_s;
  logic [PAGE_BUF_WORDS-1:0][31:0] words_s;

  function automatic logic [31:0] mux_code(input coef_state_e st, input logic [PAGE_W-1:0] pg);
    logic [31:0] code;
    case (st)
      ST_COMMIT: code = page_mux(pg, 32'(PARK_MUX));
      ST_BYPASS: code = MUX_BYPASS;
      default:   code = 32'(PARK_MUX);
    endcase
    return code;
  endfunction

  assign accept_s     = coef_valid & coef_ready_r;
  assign final_page_s = (page_r == PAGE_W'(NUM_PAGES));
  assign page_full_s  = final_page_s ? (idx_r == IDX_W'(LAST_WORDS - 1))
                                     : (idx_r == IDX_W'(PAGE_WORDS - 1));

  // next-state and page-buffer control
  always_comb begin
    state_s     = state_r;
    page_s      = page_r;
    idx_s       = idx_r;
    cyc_s       = cyc_r;
    last_seen_s = last_seen_r;
    buf_clr_s   = 1'b0;
    buf_wr_s    = 1'b0;
    buf_zfill_s = 1'b0;
    set_short_s = 1'b0;
    set_long_s  = 1'b0;
    clr_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (coef_valid) begin
          state_s     = ST_FILL;
          page_s      = PAGE_W'(1);
          idx_s       = IDX_W'(0);
          last_seen_s = 1'b0;
          buf_clr_s   = 1'b1;
        end else if (bypass_req) begin
          state_s = ST_BYPASS;
          cyc_s   = CYC_W'(0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (accept_s) begin
          buf_wr_s  = 1'b1;
          clr_err_s = (page_r == PAGE_W'(1)) && (idx_r == IDX_W'(0));
          if (coef_last) begin
            // an early last ends the frame: blank the rest and commit as final
            last_seen_s = 1'b1;
            buf_zfill_s = 1'b1;
            set_short_s = !(final_page_s && page_full_s);
            state_s     = ST_COMMIT;
            cyc_s       = CYC_W'(0);
          end else if (page_full_s) begin
            buf_zfill_s = final_page_s;
            state_s     = ST_COMMIT;
            cyc_s       = CYC_W'(0);
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_COMMIT: begin
        if (cyc_r == CYC_W'(COMMIT_CYCLES - 1)) begin
          if (last_seen_r) begin
            state_s = ST_DONE;
          end else if (final_page_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_FILL;
            page_s  = page_r + PAGE_W'(1);
            idx_s   = IDX_W'(0);
          end
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
      ST_DRAIN: begin
        if (accept_s && coef_last) begin
          set_long_s = 1'b1;
          state_s    = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_BYPASS: begin
        if (cyc_r == CYC_W'(COMMIT_CYCLES - 1)) begin
          state_s = ST_DONE;
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // state and outputs, registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      page_r       <= PAGE_W'(0);
      idx_r        <= IDX_W'(0);
      cyc_r        <= CYC_W'(0);
      last_seen_r  <= 1'b0;
      coef_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_short_r  <= 1'b0;
      err_long_r   <= 1'b0;
      coef_mux_r   <= 32'(PARK_MUX);
    end else begin
      state_r      <= state_s;
      page_r       <= page_s;
      idx_r        <= idx_s;
      cyc_r        <= cyc_s;
      last_seen_r  <= last_seen_s;
      coef_ready_r <= (state_s == ST_FILL) || (state_s == ST_DRAIN);
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      coef_mux_r   <= mux_code(state_s, page_s);
      if (set_short_s) begin
        err_short_r <= 1'b1;
      end else if (clr_err_s) begin
        err_short_r <= 1'b0;
      end else begin
        err_short_r <= err_short_r;
      end
      if (set_long_s) begin
        err_long_r <= 1'b1;
      end else if (clr_err_s) begin
        err_long_r <= 1'b0;
      end else begin
        err_long_r <= err_long_r;
      end
    end
  end

  coef_page_buf #(
    .DEPTH (PAGE_BUF_WORDS),
    .IDX_W (IDX_W)
  ) u_page_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (buf_clr_s),
    .wr_en   (buf_wr_s),
    .zfill   (buf_zfill_s),
    .wr_idx  (idx_r),
    .wr_data (coef_data),
    .words   (words_s)
  );

`ifdef COEF_CHECKSUM_EN
  logic [31:0] sum_acc_r;
  logic [31:0] checksum_r;
  logic        frame_done_s;

  assign frame_done_s = (state_s == ST_DONE) && (state_r != ST_BYPASS);

  // running sum of stored words, published when the frame completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_acc_r  <= 32'd0;
      checksum_r <= 32'd0;
    end else begin
      if (buf_wr_s) begin
        sum_acc_r <= clr_err_s ? coef_data : (sum_acc_r + coef_data);
      end else begin
        sum_acc_r <= sum_acc_r;
      end
      if (frame_done_s) begin
        checksum_r <= sum_acc_r;
      end else begin
        checksum_r <= checksum_r;
      end
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 32'd0;
`endif

  assign coef_ready  = coef_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_short   = err_short_r;
  assign err_long    = err_long_r;
  assign coef_mux    = coef_mux_r;
  assign page_word_0 = words_s[0];
  assign page_word_1 = words_s[1];
  assign page_word_2 = words_s[2];
  assign page_word_3 = words_s[3];
  assign page_word_4 = words_s[4];
  assign page_word_5 = words_s[5];
  assign page_word_6 = words_s[6];
  assign page_word_7 = words_s[7];
  assign page_word_8 = words_s[8];
  assign page_word_9 = words_s[9];

endmodule

// File: tb/tb_coef_page_loader.sv
// Randomized bench for coef_page_loader; expected pages, flags and checksum come
// from a frame-level model (stored = first 33 words, pages of 10, zero padding).
module tb_coef_page_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        coef_valid;
  logic        coef_ready;
  logic [31:0] coef_data;
  logic        coef_last;
  logic        bypass_req;
  logic [31:0] coef_mux;
  logic [31:0] pw0, pw1, pw2, pw3, pw4, pw5, pw6, pw7, pw8, pw9;
  logic        busy, done, err_short, err_long;
  logic [31:0] checksum;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  com_mux_q[$];
  logic [319:0] com_words_q[$];
  logic [31:0]  sent[$];
  int           done_cnt;
  int           xfer_cnt;

  always #5 clk = ~clk;

  coef_page_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_data   (coef_data),
    .coef_last   (coef_last),
    .bypass_req  (bypass_req),
    .coef_mux    (coef_mux),
    .page_word_0 (pw0),
    .page_word_1 (pw1),
    .page_word_2 (pw2),
    .page_word_3 (pw3),
    .page_word_4 (pw4),
    .page_word_5 (pw5),
    .page_word_6 (pw6),
    .page_word_7 (pw7),
    .page_word_8 (pw8),
    .page_word_9 (pw9),
    .busy        (busy),
    .done        (done),
    .err_short   (err_short),
    .err_long    (err_long),
    .checksum    (checksum)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // record every non-park mux cycle with the page it presents, and count done pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if (coef_mux != 32'd15) begin
        com_mux_q.push_back(coef_mux);
        com_words_q.push_back({pw9, pw8, pw7, pw6, pw5, pw4, pw3, pw2, pw1, pw0});
      end
      if (done) done_cnt++;
    end
  end

  // actual transfers as the DUT sees them
  always @(posedge clk) begin
    if (reset_n && coef_valid && coef_ready) xfer_cnt++;
  end

  task automatic clear_mon();
    com_mux_q.delete();
    com_words_q.delete();
    done_cnt = 0;
    xfer_cnt = 0;
  endtask

  task automatic send_frame(input int n, input bit with_last, input int gap_pct, input bit seq_data);
    sent.delete();
    for (int i = 0; i < n; i++) begin
      int          guard;
      bit          rdy;
      logic [31:0] w;
      bypass_req = (i > 0 && i < n - 1) ? 1'($urandom_range(1)) : 1'b0;
      guard = 0;
      while (($urandom_range(99) < gap_pct) && guard < 8) begin
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        @(negedge clk);
        guard++;
      end
      w          = seq_data ? (32'h100 + 32'(i)) : 32'($urandom());
      coef_valid = 1'b1;
      coef_data  = w;
      coef_last  = with_last && (i == n - 1);
      guard      = 0;
      forever begin
        rdy = coef_ready;
        @(posedge clk);
        if (rdy) break;
        @(negedge clk);
        guard++;
        if (guard > 100) begin
          check_val("handshake_timeout", 64'(guard), 64'd0);
          break;
        end
      end
      sent.push_back(w);
      @(negedge clk);
    end
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    bypass_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int n, input int gap_pct, input bit seq_data);
    int          stored, pages, ncmp;
    logic [31:0] sum;
    logic [31:0] expw;
    clear_mon();
    send_frame(n, 1'b1, gap_pct, seq_data);
    wait_idle(tag);
    stored = (n < 33) ? n : 33;
    pages  = (stored + 9) / 10;
    sum    = 32'd0;
    for (int i = 0; i < stored; i++) sum = sum + sent[i];
    check_val({tag, "_commit_cycles"}, 64'(com_mux_q.size()), 64'(pages * 2));
    ncmp = (com_mux_q.size() < pages * 2) ? com_mux_q.size() : pages * 2;
    for (int c = 0; c < ncmp; c++) begin
      int p;
      p = c / 2;
      check_val($sformatf("%s_mux_c%0d", tag, c), 64'(com_mux_q[c]), 64'(p + 1));
      for (int k = 0; k < 10; k++) begin
        int idx;
        idx  = p * 10 + k;
        expw = (idx < stored) ? sent[idx] : 32'd0;
        check_val($sformatf("%s_p%0d_w%0d_c%0d", tag, p + 1, k, c),
                  64'(com_words_q[c][k*32 +: 32]), 64'(expw));
      end
    end
    check_val({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_transfers"}, 64'(xfer_cnt), 64'(n));
    check_val({tag, "_err_short"}, 64'(err_short), 64'(n < 33));
    check_val({tag, "_err_long"}, 64'(err_long), 64'(n > 33));
    check_val({tag, "_mux_park"}, 64'(coef_mux), 64'd15);
`ifdef COEF_CHECKSUM_EN
    check_val({tag, "_checksum"}, 64'(checksum), 64'(sum));
`else
    check_val({tag, "_checksum"}, 64'(checksum), 64'd0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_mux"}, 64'(coef_mux), 64'd15);
    check_val({tag, "_ready"}, 64'(coef_ready), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_errs"}, 64'({err_short, err_long}), 64'd0);
    check_val({tag, "_pages_or"}, 64'(pw0 | pw1 | pw2 | pw3 | pw4 | pw5 | pw6 | pw7 | pw8 | pw9), 64'd0);
    check_val({tag, "_checksum"}, 64'(checksum), 64'd0);
  endtask

  task automatic run_bypass(input string tag);
    clear_mon();
    bypass_req = 1'b1;
    coef_valid = 1'b0;
    @(negedge clk);
    bypass_req = 1'b0;
    wait_idle(tag);
    check_val({tag, "_cycles"}, 64'(com_mux_q.size()), 64'd2);
    for (int c = 0; c < com_mux_q.size() && c < 2; c++) begin
      check_val($sformatf("%s_mux_c%0d", tag, c), 64'(com_mux_q[c]), 64'd0);
    end
    check_val({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_mux_park"}, 64'(coef_mux), 64'd15);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[9];
    lens = '{1, 9, 10, 11, 30, 32, 33, 34, 40};
    reset_n    = 1'b0;
    coef_valid = 1'b0;
    coef_data  = 32'd0;
    coef_last  = 1'b0;
    bypass_req = 1'b0;
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_frame("full", 33, 0, 1'b1);
    run_frame("short", 12, 0, 1'b1);
    run_frame("long", 36, 20, 1'b0);
    run_bypass("bypass");

    clear_mon();
    send_frame(15, 1'b0, 20, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame("after_rst", 33, 30, 1'b0);

    run_frame("backpressure", 33, 50, 1'b1);
    for (int r = 0; r < 8; r++) begin
      run_frame($sformatf("rand%0d", r), lens[$urandom_range(8)], int'($urandom_range(40)), 1'b0);
    end
    run_bypass("bypass2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coef_page_loader.md
COEF_PAGE_LOADER -- requirements
Module: coef_page_loader

Interface
REQ-001 SHALL have parameter NUM_COEF, default 33, total filter coefficients per frame.
REQ-002 SHALL have parameter PAGE_WORDS, default 10, words per coefficient page.
REQ-003 SHALL have parameter COMMIT_CYCLES, default 2, cycles each page is presented.
REQ-004 SHALL have parameter PARK_MUX, default 15, idle coef_mux value that selects no page.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports coef_valid/coef_ready  in/out  1  stream handshake; a word transfers when both are high on a clk edge.
REQ-008 SHALL have ports coef_data  in  32  and coef_last  in  1  marking the final word of a frame.
REQ-009 SHALL have port bypass_req  in  1  a level request to put the filter in bypass.
REQ-010 SHALL have port coef_mux  out  32  page select: 0 = bypass, 1..4 = page, PARK_MUX = idle.
REQ-011 SHALL have ports page_word_0..page_word_9  out  32 each  page data, registered.
REQ-012 SHALL have ports busy, done, err_short, err_long  out  1 each.

Function
REQ-013 SHALL run FSM IDLE -> FILL -> COMMIT -> (FILL | DRAIN | DONE) -> IDLE, plus BYPASS.
REQ-014 SHALL move IDLE -> FILL on the first coef_valid, and IDLE -> BYPASS when bypass_req is high with coef_valid low.
REQ-015 SHALL hold coef_ready high only in FILL and DRAIN.
REQ-016 SHALL store accepted words into page_word_k, where k is the word index within the current page.
REQ-017 SHALL go FILL -> COMMIT when the page is full: PAGE_WORDS words, or 3 words for the final page (coefficients 30..32).
REQ-018 SHALL zero-fill the remaining page_word_k when coef_last arrives early, go to COMMIT, set err_short, and treat that page as final.
REQ-019 SHALL in COMMIT drive coef_mux = page number (1..4) for exactly COMMIT_CYCLES cycles with page_word_* stable.
REQ-020 SHALL after COMMIT go to FILL (more pages), to DONE (last word had coef_last), or to DRAIN (final page full without coef_last).
REQ-021 SHALL in DRAIN accept and discard words until coef_last, set err_long, then go to DONE.
REQ-022 SHALL in DONE pulse done for one cycle, return coef_mux to PARK_MUX and go to IDLE.
REQ-023 SHALL in BYPASS drive coef_mux = 0 for COMMIT_CYCLES cycles, pulse done, then go to IDLE.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL ignore bypass_req outside IDLE.
REQ-026 SHALL clear err_short and err_long on the first accepted word of each new frame.
REQ-027 SHALL drive coef_mux = PARK_MUX in IDLE, FILL and DRAIN.

Reset
REQ-028 SHALL on reset_n low immediately force state IDLE, coef_mux = PARK_MUX, page_word_* = 0, and coef_ready/busy/done/err_* = 0.
REQ-029 SHALL discard any partial frame when reset occurs mid-frame and write no page on release.

Configuration
REQ-030 SHALL, with COEF_CHECKSUM_EN defined, add output checksum (32 bit, modulo-2^32 sum of a frame's stored coefficients, excluding drained words), updated at done and reset to 0.
REQ-031 SHALL, without COEF_CHECKSUM_EN, tie checksum to 0 and include no adder.

Structure
REQ-032 SHALL place the FSM state enum, PARK_MUX, NUM_COEF, PAGE_WORDS and the mux codes (BYPASS = 0, PAGE1..4) in shared package coef_pkg.
REQ-033 SHALL contain one sub-module, coef_page_buf: 10 x 32 page register with write index, zero-fill and clear.

Verification
REQ-034 SHALL cover a full frame: 33 words 0x100..0x120, last on word 33 -> coef_mux sequence 1, 2, 3, 4 (each held 2 cycles); page 4 words = 0x11E, 0x11F, 0x120, 0, ...; one done pulse; no error.
REQ-035 SHALL cover a short frame: 12 words, last on word 12 -> pages 1 and 2 committed; page 2 words 2..9 = 0; err_short = 1; pages 3 and 4 never selected.
REQ-036 SHALL cover a long frame: 36 words -> pages 1..4 committed; words 34..36 drained; err_long = 1; done after word 36.
REQ-037 SHALL cover bypass: bypass_req high in IDLE -> coef_mux = 0 for 2 cycles, then 15; done pulse.
REQ-038 SHALL cover reset mid-frame: reset_n low after word 15 -> outputs at reset values; next frame begins at page 1.
REQ-039 SHALL cover backpressure: random coef_valid gaps -> identical page contents, and no transfer while coef_ready is low.
